// File: rtl/snake_pkg.sv
// Shared types for the snake engine: movement direction, game state and the
// reverse-direction helper used to reject 180-degree turns.
package snake_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      RUN  = 2'd1,
      DEAD = 2'd2
   } state_t;

   function automatic dir_t opposite(input dir_t d);
      dir_t r;
      case (d)
         UP:      r = DOWN;
         DOWN:    r = UP;
         LEFT:    r = RIGHT;
         default: r = LEFT;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/snake_ring.sv
// Segment ring buffer: head writes new cells, tail pops vacated ones.
// Depth must be a power of two so the pointers wrap for free.
module snake_ring #(
   parameter int DEPTH = 256,
   parameter int W     = 13
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_cell,
   input  logic         pop,
   output logic [W-1:0] tail_cell
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only read after being seeded.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= push_cell;
   end

   assign tail_cell = mem[rd_ptr_q];

endmodule

// File: rtl/snake_engine.sv
// Snake game engine: seeding, stepping, growth, collision and cell rendering.
// Define SNAKE_WRAP_EN to wrap at the playfield edges instead of dying there.
module snake_engine
   import snake_pkg::*;
#(
   parameter int GRID_W         = 80,
   parameter int GRID_H         = 60,
   parameter int CELL_LOG2      = 3,
   parameter int MAX_LEN        = 256,
   parameter int INIT_LEN       = 4,
   parameter int STEP_DIV       = 2500000,
   parameter int GROW_PER_APPLE = 2
) (
   input  logic                         clk,
   input  logic                         SWRES,
   input  logic                         BTNU,
   input  logic                         BTND,
   input  logic                         BTNL,
   input  logic                         BTNR,
   input  logic                         SWPAUSE,
   input  logic                         apple_eat,
   input  logic [9:0]                   pixel_row,
   input  logic [9:0]                   pixel_column,
   output logic                         head_on,
   output logic                         body_on,
   output logic                         collided,
   output logic [$clog2(MAX_LEN+1)-1:0] length,
   output logic [$clog2(GRID_W)-1:0]    head_x,
   output logic [$clog2(GRID_H)-1:0]    head_y
);

   localparam int XW    = $clog2(GRID_W);
   localparam int YW    = $clog2(GRID_H);
   localparam int LW    = $clog2(MAX_LEN + 1);
   localparam int NCELL = GRID_W * GRID_H;
   localparam int CW    = $clog2(NCELL);
   localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int GMAX  = (1 << LW) - 1;

   function automatic logic [CW-1:0] cidx(input int x, input int y);
      return CW'(y * GRID_W + x);
   endfunction

   state_t              state_q, state_d;
   dir_t                dir_q, dir_d, pend_q, pend_d;
   logic [XW-1:0]       head_x_q, head_x_d;
   logic [YW-1:0]       head_y_q, head_y_d;
   logic [LW-1:0]       length_q, length_d;
   logic [LW-1:0]       grow_q, grow_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic                collided_q, collided_d;
   logic [NCELL-1:0]    bitmap_q, bitmap_d;
   logic                head_on_q, head_on_d;
   logic                body_on_q, body_on_d;

   logic                push, pop;
   logic [XW+YW-1:0]    push_cell, tail_cell;

   snake_ring #(.DEPTH(MAX_LEN), .W(XW + YW)) u_ring (
      .clk       (clk),
      .rst_n     (SWRES),
      .push      (push),
      .push_cell (push_cell),
      .pop       (pop),
      .tail_cell (tail_cell)
   );

   // Button decode, growth bookkeeping and next-head candidate
   dir_t             btn_dir;
   logic             btn_vld;
   int               gsum;
   logic [LW-1:0]    grow_eff;
   logic             growing;
   logic [XW:0]      nx;
   logic [YW:0]      ny;
   logic             wall_hit, self_hit, step;
   logic [CW-1:0]    nidx, tidx;
   int               seed_x;

   always_comb begin
      btn_vld = BTNU | BTNL | BTND | BTNR;
      if (BTNU)      btn_dir = UP;
      else if (BTNL) btn_dir = LEFT;
      else if (BTND) btn_dir = DOWN;
      else           btn_dir = RIGHT;

      gsum     = int'(grow_q) + (apple_eat ? GROW_PER_APPLE : 0);
      grow_eff = (gsum > GMAX) ? LW'(GMAX) : LW'(gsum);
      growing  = (grow_eff != '0) && (length_q < LW'(MAX_LEN));

      nx = {1'b0, head_x_q};
      ny = {1'b0, head_y_q};
      case (pend_q)
         UP:      ny = ny - (YW+1)'(1);
         DOWN:    ny = ny + (YW+1)'(1);
         LEFT:    nx = nx - (XW+1)'(1);
         default: nx = nx + (XW+1)'(1);
      endcase
`ifdef SNAKE_WRAP_EN
      // Underflow shows up as a huge value, so one range test covers both edges.
      if (nx >= (XW+1)'(GRID_W)) nx = (pend_q == LEFT) ? (XW+1)'(GRID_W - 1) : '0;
      if (ny >= (YW+1)'(GRID_H)) ny = (pend_q == UP) ? (YW+1)'(GRID_H - 1) : '0;
      wall_hit = 1'b0;
`else
      wall_hit = (nx >= (XW+1)'(GRID_W)) || (ny >= (YW+1)'(GRID_H));
`endif
      nidx     = cidx(int'(nx), int'(ny));
      tidx     = cidx(int'(tail_cell[XW+YW-1:YW]), int'(tail_cell[YW-1:0]));
      self_hit = !wall_hit && bitmap_q[nidx] && !(!growing && (nidx == tidx));
      step     = (state_q == RUN) && !SWPAUSE && (pre_q == PRE_W'(STEP_DIV - 1));
      seed_x   = GRID_W / 4 - (INIT_LEN - 1) + int'(length_q);
   end

   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      pend_d     = pend_q;
      head_x_d   = head_x_q;
      head_y_d   = head_y_q;
      length_d   = length_q;
      grow_d     = grow_q;
      pre_d      = pre_q;
      collided_d = collided_q;
      bitmap_d   = bitmap_q;
      push       = 1'b0;
      pop        = 1'b0;
      push_cell  = {nx[XW-1:0], ny[YW-1:0]};

      case (state_q)
         INIT: begin
            // Tail is seeded first so the last seeded cell becomes the head.
            push      = 1'b1;
            push_cell = {XW'(seed_x), YW'(GRID_H / 2)};
            bitmap_d[cidx(seed_x, GRID_H / 2)] = 1'b1;
            head_x_d  = XW'(seed_x);
            head_y_d  = YW'(GRID_H / 2);
            length_d  = length_q + LW'(1);
            grow_d    = grow_eff;
            if (btn_vld && btn_dir != opposite(dir_q)) pend_d = btn_dir;
            if (length_q == LW'(INIT_LEN - 1)) state_d = RUN;
         end
         RUN: begin
            grow_d = grow_eff;
            if (btn_vld && btn_dir != opposite(dir_q)) pend_d = btn_dir;
            if (!SWPAUSE) pre_d = step ? '0 : pre_q + PRE_W'(1);
            if (step) begin
               dir_d = pend_q;
               if (wall_hit || self_hit) begin
                  state_d    = DEAD;
                  collided_d = 1'b1;
               end else begin
                  head_x_d = nx[XW-1:0];
                  head_y_d = ny[YW-1:0];
                  push     = 1'b1;
                  if (growing) begin
                     length_d = length_q + LW'(1);
                     grow_d   = grow_eff - LW'(1);
                  end else begin
                     bitmap_d[tidx] = 1'b0;
                     pop            = 1'b1;
                  end
                  // Set after the tail clear so a head entering the vacated cell stays marked.
                  bitmap_d[nidx] = 1'b1;
               end
            end
            if (length_q >= LW'(MAX_LEN)) grow_d = '0;
         end
         default: ;
      endcase
   end

   // Rendering: one-cycle registered lookup of the scanned cell
   logic [9:0]    cx, cy;
   logic          in_grid, hit_head;
   logic [CW-1:0] pidx;

   always_comb begin
      cx        = pixel_column >> CELL_LOG2;
      cy        = pixel_row >> CELL_LOG2;
      in_grid   = (cx < 10'(GRID_W)) && (cy < 10'(GRID_H));
      hit_head  = in_grid && (cx == 10'(head_x_q)) && (cy == 10'(head_y_q));
      pidx      = cidx(int'(cx), int'(cy));
      head_on_d = hit_head;
      body_on_d = in_grid && bitmap_q[pidx] && !hit_head;
   end

   always_ff @(posedge clk or negedge SWRES) begin
      if (!SWRES) begin
         state_q    <= INIT;
         dir_q      <= RIGHT;
         pend_q     <= RIGHT;
         head_x_q   <= '0;
         head_y_q   <= '0;
         length_q   <= '0;
         grow_q     <= '0;
         pre_q      <= '0;
         collided_q <= 1'b0;
         bitmap_q   <= '0;
         head_on_q  <= 1'b0;
         body_on_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         pend_q     <= pend_d;
         head_x_q   <= head_x_d;
         head_y_q   <= head_y_d;
         length_q   <= length_d;
         grow_q     <= grow_d;
         pre_q      <= pre_d;
         collided_q <= collided_d;
         bitmap_q   <= bitmap_d;
         head_on_q  <= head_on_d;
         body_on_q  <= body_on_d;
      end
   end

   assign head_on  = head_on_q;
   assign body_on  = body_on_q;
   assign collided = collided_q;
   assign length   = length_q;
   assign head_x   = head_x_q;
   assign head_y   = head_y_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine with STEP_DIV=4: seeding, stepping, growth,
// turning, self/wall collision and rendering, checked with immediate assertions.
module tb_snake_engine;

   logic       clk = 1'b0;
   logic       SWRES, BTNU, BTND, BTNL, BTNR, SWPAUSE, apple_eat;
   logic [9:0] pixel_row, pixel_column;
   logic       head_on, body_on, collided;
   logic [8:0] length;
   logic [6:0] head_x;
   logic [5:0] head_y;

   int vectors     = 0;
   int miscompares = 0;

   snake_engine #(.STEP_DIV(4)) dut (
      .clk          (clk),
      .SWRES        (SWRES),
      .BTNU         (BTNU),
      .BTND         (BTND),
      .BTNL         (BTNL),
      .BTNR         (BTNR),
      .SWPAUSE      (SWPAUSE),
      .apple_eat    (apple_eat),
      .pixel_row    (pixel_row),
      .pixel_column (pixel_column),
      .head_on      (head_on),
      .body_on      (body_on),
      .collided     (collided),
      .length       (length),
      .head_x       (head_x),
      .head_y       (head_y)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Four unpaused RUN cycles make exactly one move.
   task automatic steps(input int n);
      repeat (4 * n) tick();
   endtask

   task automatic press_step(input logic u, input logic d, input logic l, input logic r);
      BTNU = u; BTND = d; BTNL = l; BTNR = r;
      tick();
      BTNU = 0; BTND = 0; BTNL = 0; BTNR = 0;
      repeat (3) tick();
   endtask

   task automatic probe(input string tag, input int cx, input int cy, input int eh, input int eb);
      SWPAUSE      = 1'b1;
      pixel_column = 10'(cx * 8);
      pixel_row    = 10'(cy * 8);
      tick();
      tick();
      check({tag, ".head_on"}, int'(head_on), eh);
      check({tag, ".body_on"}, int'(body_on), eb);
      SWPAUSE = 1'b0;
   endtask

   task automatic do_reset();
      SWRES = 1'b0;
      #1;
      check("async_rst.length", int'(length), 0);
      check("async_rst.collided", int'(collided), 0);
      tick();
      SWRES = 1'b1;
      repeat (4) tick();
   endtask

   initial begin
      SWRES = 0; BTNU = 0; BTND = 0; BTNL = 0; BTNR = 0;
      SWPAUSE = 0; apple_eat = 0; pixel_row = 0; pixel_column = 0;
      repeat (3) tick();
      check("rst.length", int'(length), 0);
      check("rst.collided", int'(collided), 0);
      check("rst.head_on", int'(head_on), 0);
      check("rst.body_on", int'(body_on), 0);

      // Seeding
      SWRES = 1'b1;
      repeat (4) tick();
      check("init.length", int'(length), 4);
      check("init.head_x", int'(head_x), 20);
      check("init.head_y", int'(head_y), 30);
      probe("init.tail17", 17, 30, 0, 1);
      probe("init.head20", 20, 30, 1, 0);
      probe("init.c16", 16, 30, 0, 0);
      probe("init.offgrid", 80, 30, 0, 0);

      // Plain movement
      steps(5);
      check("run5.head_x", int'(head_x), 25);
      check("run5.head_y", int'(head_y), 30);
      check("run5.length", int'(length), 4);
      probe("run5.c21", 21, 30, 0, 0);
      probe("run5.c22", 22, 30, 0, 1);

      // Pause freezes movement
      SWPAUSE = 1'b1;
      repeat (12) tick();
      SWPAUSE = 1'b0;
      check("pause.head_x", int'(head_x), 25);

      // Growth
      apple_eat = 1'b1;
      tick();
      apple_eat = 1'b0;
      repeat (3) tick();
      check("grow1.length", int'(length), 5);
      steps(2);
      check("grow3.length", int'(length), 6);
      check("grow3.head_x", int'(head_x), 28);
      steps(1);
      check("grow4.length", int'(length), 6);
      check("grow4.head_x", int'(head_x), 29);
      probe("grow4.c23", 23, 30, 0, 0);
      probe("grow4.c24", 24, 30, 0, 1);

      // Reverse request ignored, then turn up
      press_step(0, 0, 1, 0);
      check("revL.head_x", int'(head_x), 30);
      check("revL.head_y", int'(head_y), 30);
      press_step(1, 0, 0, 0);
      check("up.head_x", int'(head_x), 30);
      check("up.head_y", int'(head_y), 29);
      press_step(0, 0, 1, 0);
      check("left.head_x", int'(head_x), 29);
      check("left.collided", int'(collided), 0);

      // Turn down into own body
      press_step(0, 1, 0, 0);
      check("selfhit.collided", int'(collided), 1);
      check("selfhit.head_x", int'(head_x), 29);
      check("selfhit.head_y", int'(head_y), 29);
      steps(3);
      check("dead.head_y", int'(head_y), 29);
      check("dead.length", int'(length), 6);
      probe("dead.body", 30, 29, 0, 1);
      probe("dead.head", 29, 29, 1, 0);

      // Length-4 loop into the vacating tail; U+D together resolves to U
      do_reset();
      check("loop.init_len", int'(length), 4);
      press_step(1, 1, 0, 0);
      check("loop.up_x", int'(head_x), 20);
      check("loop.up_y", int'(head_y), 29);
      press_step(0, 0, 1, 0);
      check("loop.left_x", int'(head_x), 19);
      press_step(0, 1, 0, 0);
      check("loop.collided", int'(collided), 0);
      check("loop.head_x", int'(head_x), 19);
      check("loop.head_y", int'(head_y), 30);
      check("loop.length", int'(length), 4);
      probe("loop.c18", 18, 30, 0, 0);
      probe("loop.c20", 20, 30, 0, 1);

      // Right wall
      do_reset();
      steps(59);
      check("wall.pre_x", int'(head_x), 79);
      check("wall.pre_collided", int'(collided), 0);
      steps(1);
`ifdef SNAKE_WRAP_EN
      check("wall.collided", int'(collided), 0);
      check("wall.head_x", int'(head_x), 0);
`else
      check("wall.collided", int'(collided), 1);
      check("wall.head_x", int'(head_x), 79);
`endif
      check("wall.head_y", int'(head_y), 30);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
